// File: rtl/frame_buffer_arbiter.sv
// Triple-buffer controller for the shared DDR frame store: hands the camera
// writer and the HDMI reader disjoint buffers and tracks the newest complete frame.
// Ports: clk, rst_n (async, active-low), wr_frame_done / rd_frame_start pulses in;
// wr/rd base addresses and buffer indices, rd_has_frame, drop_cnt, repeat_cnt out.
// Optional macro FB_STATS_EN builds the drop/repeat counters (otherwise tied to 0).
module frame_buffer_arbiter #(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h1000_0000,
  parameter int                FRAME_BYTES = 153600
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_frame_done,
  input  logic              rd_frame_start,
  output logic [ADDR_W-1:0] wr_base_addr,
  output logic [ADDR_W-1:0] rd_base_addr,
  output logic [1:0]        wr_buf_idx,
  output logic [1:0]        rd_buf_idx,
  output logic              rd_has_frame,
  output logic [15:0]       drop_cnt,
  output logic [15:0]       repeat_cnt
);

  localparam logic [ADDR_W-1:0] ADDR_0 = BASE_ADDR;
  localparam logic [ADDR_W-1:0] ADDR_1 =
    BASE_ADDR + ADDR_W'(FRAME_BYTES);
  localparam logic [ADDR_W-1:0] ADDR_2 =
    BASE_ADDR + ADDR_W'(2 * FRAME_BYTES);

  function automatic logic [ADDR_W-1:0] base_of(
    input logic [1:0] idx
  );
    logic [ADDR_W-1:0] a;
    case (idx)
      2'd0:    a = ADDR_0;
      2'd1:    a = ADDR_1;
      default: a = ADDR_2;
    endcase
    return a;
  endfunction

  logic [1:0]        wr_q, wr_d;
  logic [1:0]        rd_q, rd_d;
  logic [1:0]        rdy_q, rdy_d;
  logic              rdy_valid_q, rdy_valid_d;
  logic              has_frame_q, has_frame_d;
  logic [ADDR_W-1:0] wr_base_q, wr_base_d;
  logic [ADDR_W-1:0] rd_base_q, rd_base_d;
  logic              rd_take;

  // Reader swaps only when a fresh frame is parked in the ready slot.
  assign rd_take = rd_frame_start & rdy_valid_q;

  always_comb begin
    rd_d        = rd_take ? rdy_q : rd_q;
    wr_d        = wr_q;
    rdy_d       = rdy_q;
    rdy_valid_d = rdy_valid_q;
    has_frame_d = has_frame_q | rd_take;
    if (wr_frame_done) begin
      // Writer takes whichever buffer is left over after the reader
      // has (possibly) swapped in the same cycle.
      rdy_d       = wr_q;
      wr_d        = 2'd3 - rd_d - wr_q;
      rdy_valid_d = 1'b1;
    end else if (rd_take) begin
      rdy_d       = rd_q;
      rdy_valid_d = 1'b0;
    end
    wr_base_d = base_of(wr_d);
    rd_base_d = base_of(rd_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q        <= 2'd0;
      rdy_q       <= 2'd1;
      rd_q        <= 2'd2;
      rdy_valid_q <= 1'b0;
      has_frame_q <= 1'b0;
      wr_base_q   <= ADDR_0;
      rd_base_q   <= ADDR_2;
    end else begin
      wr_q        <= wr_d;
      rdy_q       <= rdy_d;
      rd_q        <= rd_d;
      rdy_valid_q <= rdy_valid_d;
      has_frame_q <= has_frame_d;
      wr_base_q   <= wr_base_d;
      rd_base_q   <= rd_base_d;
    end
  end

  assign wr_base_addr = wr_base_q;
  assign rd_base_addr = rd_base_q;
  assign wr_buf_idx   = wr_q;
  assign rd_buf_idx   = rd_q;
  assign rd_has_frame = has_frame_q;

`ifdef FB_STATS_EN
  logic [15:0] drop_q, drop_d;
  logic [15:0] rep_q, rep_d;
  logic        drop_ev;
  logic        rep_ev;

  // A finished frame replaced an undisplayed one.
  assign drop_ev = wr_frame_done & rdy_valid_q & ~rd_take;
  assign rep_ev  = rd_frame_start & ~rdy_valid_q;

  always_comb begin
    drop_d = drop_q;
    rep_d  = rep_q;
    if (drop_ev && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    if (rep_ev && rep_q != 16'hFFFF)   rep_d  = rep_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= 16'd0;
      rep_q  <= 16'd0;
    end else begin
      drop_q <= drop_d;
      rep_q  <= rep_d;
    end
  end

  assign drop_cnt   = drop_q;
  assign repeat_cnt = rep_q;
`else
  assign drop_cnt   = 16'd0;
  assign repeat_cnt = 16'd0;
`endif

endmodule

// File: doc/frame_buffer_arbiter.md
# frame_buffer_arbiter

Triple-buffer controller for the DDR frame store shared by the camera write path (AXI4 writer) and the HDMI read path (AXI4 reader). It owns three frame buffers in DDR and hands out a write base address and a read base address so the writer never overwrites the frame being displayed. The reader always gets the most recently completed frame. It runs in the 100 MHz AXI clock domain. Frame events from the pixel-clock and 25 MHz domains arrive as single-cycle pulses already synchronized to `clk`.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `BASE_ADDR`, 32'h1000_0000: byte address of buffer 0. Must be 8-byte aligned.
- `FRAME_BYTES`, 153600: bytes per buffer (320×240×2). Must be a multiple of 8.

Ports:
- `clk` in 1: 100 MHz AXI clock; all logic is in this domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_frame_done` in 1: 1-cycle pulse; the writer has finished the last burst of a frame.
- `rd_frame_start` in 1: 1-cycle pulse at display VSYNC; the reader is about to fetch a new frame.
- `wr_base_addr` out ADDR_W: base address the writer uses for its next frame.
- `rd_base_addr` out ADDR_W: base address the reader uses for its current frame.
- `wr_buf_idx` out 2: buffer index currently owned by the writer (0..2).
- `rd_buf_idx` out 2: buffer index currently owned by the reader (0..2).
- `rd_has_frame` out 1: 1 once the reader holds at least one completed frame. The reader outputs black while this is 0.
- `drop_cnt` out 16: count of completed frames that were overwritten before being displayed.
- `repeat_cnt` out 16: count of `rd_frame_start` events with no new frame available.

## Operation
- State:
  - `wr_idx`, `rd_idx`, `rdy_idx` (2 bits each).
  - `rdy_valid` (1 bit).
- Invariant: {wr_idx, rd_idx, rdy_idx} is always a permutation of {0,1,2}. Each value 3 is illegal and must never occur.
- Next-state rules, evaluated on each rising edge of `clk`:
  - new_rd = (rd_frame_start & rdy_valid) ? rdy_idx : rd_idx.
  - If `wr_frame_done`:
    - new_rdy = wr_idx.
    - new_wr = 3 − new_rd − new_rdy.
    - rdy_valid ← 1.
  - Else if `rd_frame_start & rdy_valid`:
    - new_rdy = rd_idx (stale).
    - wr unchanged.
    - rdy_valid ← 0.
  - Else: no change.
- Simultaneous `wr_frame_done` and `rd_frame_start`: the reader takes the old ready frame first. The just-completed frame then becomes the new ready frame, and rdy_valid ends at 1.
- Drop: if `wr_frame_done` arrives while rdy_valid=1 and the reader does not consume that frame in the same cycle, `drop_cnt` increments.
- Repeat: if `rd_frame_start` arrives while rdy_valid=0, then rd_idx is held and `repeat_cnt` increments.
- `rd_has_frame` is set by the first successful reader swap. Only reset clears it.
- Address calculation: base = BASE_ADDR + idx × FRAME_BYTES, computed in ADDR_W bits with modulo-2^ADDR_W wrap. It is registered from the next-state index, so addresses and indices change on the same edge.
- Counters saturate at 16'hFFFF and never wrap.

## Timing
- Latency: an event sampled on edge N is visible on all outputs after edge N (1 cycle). No combinational paths from inputs to outputs.
- A pulse held high for k cycles is treated as k events. The source guarantees single-cycle pulses.
- Reset values:
  - wr_buf_idx=0, rdy_idx=1, rd_buf_idx=2, rdy_valid=0.
  - wr_base_addr=BASE_ADDR.
  - rd_base_addr=BASE_ADDR+2×FRAME_BYTES.
  - rd_has_frame=0, drop_cnt=0, repeat_cnt=0.
- Reset asserted mid-frame forces all reset values immediately, without waiting for a clock edge. The first event is sampled on the first edge after `rst_n` deasserts.

## Configuration
- `FB_STATS_EN` defined: `drop_cnt` and `repeat_cnt` are implemented as described above.
- `FB_STATS_EN` undefined: counters are not built. Both ports still exist and are constant 0. Buffer sequencing is identical in both builds.

## Test plan
- Reset: hold `rst_n`=0, then release. Expect wr_buf_idx=0, rd_buf_idx=2, wr_base=0x1000_0000, rd_base=0x1004_B000, rd_has_frame=0, both counters 0.
- Single frame: pulse `wr_frame_done`. Expect wr_buf_idx=1 and wr_base=0x1002_5800. Then pulse `rd_frame_start`. Expect rd_buf_idx=0, rd_base=0x1000_0000, rd_has_frame=1.
- Drop: starting from reset, pulse `wr_frame_done` twice with no `rd_frame_start`. Expect drop_cnt=1, wr_buf_idx=0, rd_buf_idx=2, and the permutation held.
- Repeat: starting from reset, pulse `rd_frame_start`. Expect rd_buf_idx=2 unchanged, repeat_cnt=1, rd_has_frame=0.
- Simultaneous: from state wr=1, rdy=0 (valid), rd=2, pulse both inputs on the same cycle. Expect rd=0 (rd_base 0x1000_0000), rdy=1 valid, wr=2 (wr_base 0x1004_B000), drop_cnt unchanged.
- Async reset mid-operation: after 5 random events, drop `rst_n` between clock edges. Expect all outputs at reset values before the next edge. In a random 10k-event run, check the permutation invariant every cycle and check that wr_buf_idx≠rd_buf_idx always.
